// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port, variable-latency memory bus between the
// instruction-fetch requester (I) and the load/store requester (D). Data wins over
// fetch, except that I is forced through after STARVE_LIMIT consecutive D wins while
// I is waiting. Only one transaction is ever outstanding.
// Optional response watchdog: define ARB_TIMEOUT_EN to enable it (limit = TIMEOUT).
module mem_port_arbiter #(
   parameter int STARVE_LIMIT = 4,
   parameter int TIMEOUT      = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_req,
   input  logic [31:0] i_addr,
   output logic        i_gnt,
   output logic        i_rvalid,
   output logic [31:0] i_rdata,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   input  logic [3:0]  d_wstrb,
   output logic        d_gnt,
   output logic        d_rvalid,
   output logic [31:0] d_rdata,
   output logic        m_req,
   output logic        m_we,
   output logic [31:0] m_addr,
   output logic [31:0] m_wdata,
   output logic [3:0]  m_wstrb,
   input  logic        m_gnt,
   input  logic        m_rvalid,
   input  logic [31:0] m_rdata,
   output logic        busy,
   output logic        err
);

   localparam int SW = $clog2(STARVE_LIMIT + 1);
   localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
   // Instruction returned to the fetch stage when the watchdog abandons a fetch.
   localparam logic [31:0] NOP_INSN = 32'h0000_0013;

   typedef enum logic [1:0] {IDLE, WAIT_I, WAIT_D} state_t;

   state_t        r_state;
   state_t        w_nextState;
   logic [SW-1:0] r_starveCnt;
   logic          w_selI;
   logic          w_selD;
   logic          w_timeout;

`ifdef ARB_TIMEOUT_EN
   localparam int WW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

   logic [WW-1:0] r_wdCnt;

   assign w_timeout = (r_wdCnt == WW'(TIMEOUT)) & ~m_rvalid;

   // Watchdog: counts silent WAIT cycles; held at zero in IDLE so every WAIT starts fresh.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wdCnt <= '0;
      end else if (r_state == IDLE) begin
         r_wdCnt <= '0;
      end else if (!m_rvalid) begin
         r_wdCnt <= r_wdCnt + WW'(1);
      end
   end
`else
   logic w_unusedTimeout;

   assign w_timeout       = 1'b0;
   assign w_unusedTimeout = ^TIMEOUT;
`endif

   // State register; a reset mid-transaction simply abandons the outstanding access.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Starvation counter: consecutive D grants while I keeps waiting, saturating.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_starveCnt <= '0;
      end else if (i_gnt || !i_req) begin
         r_starveCnt <= '0;
      end else if (d_gnt && (r_starveCnt != STARVE_MAX)) begin
         r_starveCnt <= r_starveCnt + SW'(1);
      end
   end

   // Arbitration, bus muxing, response routing and next-state selection.
   always_comb begin
      w_nextState = r_state;
      w_selI      = 1'b0;
      w_selD      = 1'b0;
      m_req       = 1'b0;
      m_we        = 1'b0;
      m_addr      = 32'h0;
      m_wdata     = 32'h0;
      m_wstrb     = 4'h0;
      i_gnt       = 1'b0;
      d_gnt       = 1'b0;
      i_rvalid    = 1'b0;
      i_rdata     = 32'h0;
      d_rvalid    = 1'b0;
      d_rdata     = 32'h0;
      err         = 1'b0;
      busy        = (r_state != IDLE);

      case (r_state)
         IDLE: begin
            w_selI = i_req & (~d_req | (r_starveCnt == STARVE_MAX));
            w_selD = d_req & ~w_selI;
            m_req  = w_selI | w_selD;
            if (w_selI) begin
               m_addr = i_addr;
            end else if (w_selD) begin
               m_we    = d_we;
               m_addr  = d_addr;
               m_wdata = d_wdata;
               m_wstrb = d_wstrb;
            end
            i_gnt = w_selI & m_gnt;
            d_gnt = w_selD & m_gnt;
            if (i_gnt) begin
               w_nextState = WAIT_I;
            end else if (d_gnt) begin
               w_nextState = WAIT_D;
            end
         end
         WAIT_I: begin
            if (m_rvalid) begin
               i_rvalid    = 1'b1;
               i_rdata     = m_rdata;
               w_nextState = IDLE;
            end else if (w_timeout) begin
               i_rvalid    = 1'b1;
               i_rdata     = NOP_INSN;
               err         = 1'b1;
               w_nextState = IDLE;
            end
         end
         WAIT_D: begin
            if (m_rvalid) begin
               d_rvalid    = 1'b1;
               d_rdata     = m_rdata;
               w_nextState = IDLE;
            end else if (w_timeout) begin
               d_rvalid    = 1'b1;
               d_rdata     = NOP_INSN;
               err         = 1'b1;
               w_nextState = IDLE;
            end
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: self-checking bench for mem_port_arbiter.
// Table of combinational arbitration vectors, directed multi-cycle sequences, and a
// randomized phase scored against a transaction-level model of the arbiter.
// The watchdog sequence is compiled only when ARB_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

   localparam int STARVE_LIMIT = 4;
   localparam int TIMEOUT      = 8;
   localparam int RAND_CYCLES  = 400;

   logic        clk;
   logic        reset;
   logic        iReq;
   logic [31:0] iAddr;
   logic        iGnt;
   logic        iRvalid;
   logic [31:0] iRdata;
   logic        dReq;
   logic        dWe;
   logic [31:0] dAddr;
   logic [31:0] dWdata;
   logic [3:0]  dWstrb;
   logic        dGnt;
   logic        dRvalid;
   logic [31:0] dRdata;
   logic        mReq;
   logic        mWe;
   logic [31:0] mAddr;
   logic [31:0] mWdata;
   logic [3:0]  mWstrb;
   logic        mGnt;
   logic        mRvalid;
   logic [31:0] mRdata;
   logic        busy;
   logic        err;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic        iReq;
      logic [31:0] iAddr;
      logic        dReq;
      logic        dWe;
      logic [31:0] dAddr;
      logic [31:0] dWdata;
      logic [3:0]  dWstrb;
      logic        mGnt;
      logic        expMReq;
      logic        expMWe;
      logic [31:0] expMAddr;
      logic [31:0] expMWdata;
      logic [3:0]  expMWstrb;
      logic        expIGnt;
      logic        expDGnt;
   } vec_t;

   vec_t vecs[6];

   mem_port_arbiter #(
      .STARVE_LIMIT(STARVE_LIMIT),
      .TIMEOUT     (TIMEOUT)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .i_req   (iReq),
      .i_addr  (iAddr),
      .i_gnt   (iGnt),
      .i_rvalid(iRvalid),
      .i_rdata (iRdata),
      .d_req   (dReq),
      .d_we    (dWe),
      .d_addr  (dAddr),
      .d_wdata (dWdata),
      .d_wstrb (dWstrb),
      .d_gnt   (dGnt),
      .d_rvalid(dRvalid),
      .d_rdata (dRdata),
      .m_req   (mReq),
      .m_we    (mWe),
      .m_addr  (mAddr),
      .m_wdata (mWdata),
      .m_wstrb (mWstrb),
      .m_gnt   (mGnt),
      .m_rvalid(mRvalid),
      .m_rdata (mRdata),
      .busy    (busy),
      .err     (err)
   );

   // Free-running clock, 10 ns period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard stop in case anything above ever stalls.
   initial begin
      #200000;
      $display("[TB] FAIL global_timeout: simulation did not finish, failures so far %0d", failures);
      $fatal(1, "[TB] global timeout");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      end
   endtask

   // Move to just after the next rising edge, where inputs are changed.
   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idleInputs();
      iReq    = 1'b0;
      iAddr   = 32'h0;
      dReq    = 1'b0;
      dWe     = 1'b0;
      dAddr   = 32'h0;
      dWdata  = 32'h0;
      dWstrb  = 4'h0;
      mGnt    = 1'b0;
      mRvalid = 1'b0;
      mRdata  = 32'h0;
   endtask

   task automatic applyStimulus(input vec_t v);
      iReq    = v.iReq;
      iAddr   = v.iAddr;
      dReq    = v.dReq;
      dWe     = v.dWe;
      dAddr   = v.dAddr;
      dWdata  = v.dWdata;
      dWstrb  = v.dWstrb;
      mGnt    = v.mGnt;
      mRvalid = 1'b0;
      mRdata  = 32'h0;
   endtask

   task automatic doReset();
      reset = 1'b1;
      idleInputs();
      nextCycle();
      nextCycle();
      reset = 1'b0;
   endtask

   // Main sequence.
   initial begin
      bit          mBusy;
      bit          mOwnerI;
      int          mWaitCnt;
      int          mLat;
      int          mStarve;
      bit          iHeld;
      bit          dHeld;
      bit          respond;
      bit          winI;
      bit          winD;
      logic        eIGnt;
      logic        eDGnt;
      logic [31:0] eAddr;

      reset = 1'b1;
      idleInputs();
      vecs[0] = '{1'b0, 32'h1234, 1'b0, 1'b1, 32'h200, 32'hAAAA5555, 4'hF, 1'b1,
                  1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0};
      vecs[1] = '{1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0,
                  1'b1, 1'b0, 32'h40, 32'h0, 4'h0, 1'b0, 1'b0};
      vecs[2] = '{1'b1, 32'h44, 1'b0, 1'b1, 32'h300, 32'hCAFEF00D, 4'hF, 1'b1,
                  1'b1, 1'b0, 32'h44, 32'h0, 4'h0, 1'b1, 1'b0};
      vecs[3] = '{1'b0, 32'h48, 1'b1, 1'b1, 32'h104, 32'h11223344, 4'h3, 1'b1,
                  1'b1, 1'b1, 32'h104, 32'h11223344, 4'h3, 1'b0, 1'b1};
      vecs[4] = '{1'b1, 32'h4C, 1'b1, 1'b0, 32'h108, 32'h55667788, 4'h5, 1'b1,
                  1'b1, 1'b0, 32'h108, 32'h55667788, 4'h5, 1'b0, 1'b1};
      vecs[5] = '{1'b1, 32'h50, 1'b1, 1'b1, 32'h10C, 32'h99AABBCC, 4'hC, 1'b0,
                  1'b1, 1'b1, 32'h10C, 32'h99AABBCC, 4'hC, 1'b0, 1'b0};

      // Reset state.
      nextCycle();
      #3;
      checkOutput("reset busy", 32'(busy), 32'd0);
      checkOutput("reset err", 32'(err), 32'd0);
      checkOutput("reset m_req", 32'(mReq), 32'd0);
      checkOutput("reset rvalids", {30'd0, iRvalid, dRvalid}, 32'd0);
      nextCycle();
      reset = 1'b0;

      // Combinational arbitration table; requests drop before each edge so no transaction starts.
      for (int i = 0; i < 6; i++) begin
         nextCycle();
         applyStimulus(vecs[i]);
         #3;
         checkOutput($sformatf("vec%0d m_req", i), 32'(mReq), 32'(vecs[i].expMReq));
         checkOutput($sformatf("vec%0d m_we", i), 32'(mWe), 32'(vecs[i].expMWe));
         checkOutput($sformatf("vec%0d m_addr", i), mAddr, vecs[i].expMAddr);
         checkOutput($sformatf("vec%0d m_wdata", i), mWdata, vecs[i].expMWdata);
         checkOutput($sformatf("vec%0d m_wstrb", i), 32'(mWstrb), 32'(vecs[i].expMWstrb));
         checkOutput($sformatf("vec%0d i_gnt", i), 32'(iGnt), 32'(vecs[i].expIGnt));
         checkOutput($sformatf("vec%0d d_gnt", i), 32'(dGnt), 32'(vecs[i].expDGnt));
         checkOutput($sformatf("vec%0d busy", i), 32'(busy), 32'd0);
         idleInputs();
      end

      // Fetch only, one-cycle memory.
      nextCycle();
      iReq = 1'b1; iAddr = 32'h0; mGnt = 1'b1;
      #3;
      checkOutput("fetch c0 i_gnt", 32'(iGnt), 32'd1);
      checkOutput("fetch c0 m_addr", mAddr, 32'h0);
      nextCycle();
      mRvalid = 1'b1; mRdata = 32'h00500293;
      #3;
      checkOutput("fetch c1 i_rvalid", 32'(iRvalid), 32'd1);
      checkOutput("fetch c1 i_rdata", iRdata, 32'h00500293);
      checkOutput("fetch c1 d_rvalid", 32'(dRvalid), 32'd0);
      checkOutput("fetch c1 m_req", 32'(mReq), 32'd0);
      nextCycle();
      mRvalid = 1'b0;
      #3;
      checkOutput("fetch c2 i_gnt", 32'(iGnt), 32'd1);
      nextCycle();
      iReq = 1'b0; mRvalid = 1'b1;
      #3;
      checkOutput("fetch c3 i_rvalid", 32'(iRvalid), 32'd1);
      checkOutput("fetch c3 d_rvalid", 32'(dRvalid), 32'd0);
      nextCycle();
      idleInputs();

      // Both requesting at reset release: the store goes first.
      reset = 1'b1;
      iReq = 1'b1; iAddr = 32'h80; mGnt = 1'b1;
      dReq = 1'b1; dWe = 1'b1; dAddr = 32'h100; dWdata = 32'hDEADBEEF; dWstrb = 4'hF;
      nextCycle();
      reset = 1'b0;
      #3;
      checkOutput("both d_gnt", 32'(dGnt), 32'd1);
      checkOutput("both i_gnt", 32'(iGnt), 32'd0);
      checkOutput("both m_we", 32'(mWe), 32'd1);
      checkOutput("both m_addr", mAddr, 32'h100);
      checkOutput("both m_wdata", mWdata, 32'hDEADBEEF);
      checkOutput("both m_wstrb", 32'(mWstrb), 32'hF);
      nextCycle();
      dReq = 1'b0;
      #3;
      checkOutput("both wait i_gnt", 32'(iGnt), 32'd0);
      checkOutput("both wait busy", 32'(busy), 32'd1);
      nextCycle();
      mRvalid = 1'b1;
      #3;
      checkOutput("both d_rvalid", 32'(dRvalid), 32'd1);
      checkOutput("both resp i_gnt", 32'(iGnt), 32'd0);
      nextCycle();
      mRvalid = 1'b0;
      #3;
      checkOutput("both later i_gnt", 32'(iGnt), 32'd1);
      checkOutput("both later m_addr", mAddr, 32'h80);
      nextCycle();
      iReq = 1'b0; mRvalid = 1'b1;
      #3;
      checkOutput("both i_rvalid", 32'(iRvalid), 32'd1);
      nextCycle();
      idleInputs();

      // Starvation guard: both held, expect D,D,D,D,I repeating.
      for (int g = 0; g < 10; g++) begin
         nextCycle();
         iReq = 1'b1; iAddr = 32'h200; dReq = 1'b1; dAddr = 32'h300; mGnt = 1'b1; mRvalid = 1'b0;
         #3;
         checkOutput($sformatf("starve grant%0d", g), {30'd0, iGnt, dGnt},
                     (g % 5 == 4) ? 32'd2 : 32'd1);
         nextCycle();
         mRvalid = 1'b1;
      end
      nextCycle();
      idleInputs();

      // Backpressure: request held while memory refuses it.
      for (int c = 0; c < 5; c++) begin
         nextCycle();
         dReq = 1'b1; dAddr = 32'h200; mGnt = 1'b0;
         #3;
         checkOutput($sformatf("bp%0d m_req", c), 32'(mReq), 32'd1);
         checkOutput($sformatf("bp%0d m_addr", c), mAddr, 32'h200);
         checkOutput($sformatf("bp%0d d_gnt", c), 32'(dGnt), 32'd0);
         checkOutput($sformatf("bp%0d busy", c), 32'(busy), 32'd0);
      end
      nextCycle();
      mGnt = 1'b1;
      #3;
      checkOutput("bp release d_gnt", 32'(dGnt), 32'd1);
      nextCycle();
      dReq = 1'b0; mGnt = 1'b0;
      #3;
      checkOutput("bp wait busy", 32'(busy), 32'd1);

      // Reset while waiting on the store, then a stale response arrives.
      reset = 1'b1;
      #1;
      checkOutput("midreset busy", 32'(busy), 32'd0);
      checkOutput("midreset d_rvalid", 32'(dRvalid), 32'd0);
      nextCycle();
      reset = 1'b0;
      mRvalid = 1'b1; mRdata = 32'h12345678;
      #3;
      checkOutput("stale d_rvalid", 32'(dRvalid), 32'd0);
      checkOutput("stale i_rvalid", 32'(iRvalid), 32'd0);
      checkOutput("stale busy", 32'(busy), 32'd0);
      nextCycle();
      mRvalid = 1'b0;
      #3;
      checkOutput("stale after busy", 32'(busy), 32'd0);

      // Randomized traffic against a transaction-level model.
      doReset();
      mBusy = 0; mOwnerI = 0; mWaitCnt = 0; mLat = 1; mStarve = 0; iHeld = 0; dHeld = 0;
      for (int n = 0; n < RAND_CYCLES; n++) begin
         nextCycle();
         if (!iHeld && $urandom_range(0, 2) == 0) begin
            iHeld = 1;
            iAddr = $urandom & 32'hFFFF_FFFC;
         end
         if (!dHeld && $urandom_range(0, 2) == 0) begin
            dHeld  = 1;
            dWe    = $urandom_range(0, 1) == 1;
            dAddr  = $urandom;
            dWdata = $urandom;
            dWstrb = 4'($urandom_range(0, 15));
         end
         iReq    = iHeld;
         dReq    = dHeld;
         mGnt    = $urandom_range(0, 3) != 0;
         respond = mBusy && (mWaitCnt == mLat - 1);
         mRvalid = respond || (!mBusy && $urandom_range(0, 7) == 0);
         mRdata  = $urandom;

         // I is chosen when D is silent or I has already lost STARVE_LIMIT times in a row.
         winI  = !mBusy && iHeld && (!dHeld || mStarve >= STARVE_LIMIT);
         winD  = !mBusy && dHeld && !winI;
         eIGnt = winI && mGnt;
         eDGnt = winD && mGnt;
         eAddr = winI ? iAddr : (winD ? dAddr : 32'h0);
         #3;
         checkOutput("rand m_req", 32'(mReq), 32'(winI || winD));
         checkOutput("rand m_addr", mAddr, eAddr);
         checkOutput("rand m_we", 32'(mWe), 32'(winD && dWe));
         checkOutput("rand m_wdata", mWdata, winD ? dWdata : 32'h0);
         checkOutput("rand m_wstrb", 32'(mWstrb), winD ? 32'(dWstrb) : 32'h0);
         checkOutput("rand i_gnt", 32'(iGnt), 32'(eIGnt));
         checkOutput("rand d_gnt", 32'(dGnt), 32'(eDGnt));
         checkOutput("rand i_rvalid", 32'(iRvalid), 32'(respond && mOwnerI));
         checkOutput("rand d_rvalid", 32'(dRvalid), 32'(respond && !mOwnerI));
         checkOutput("rand busy", 32'(busy), 32'(mBusy));
         checkOutput("rand err", 32'(err), 32'd0);
         if (respond) begin
            checkOutput("rand i_rdata", iRdata, mOwnerI ? mRdata : 32'h0);
            checkOutput("rand d_rdata", dRdata, mOwnerI ? 32'h0 : mRdata);
         end

         if (eIGnt || !iHeld) begin
            mStarve = 0;
         end else if (eDGnt && mStarve < STARVE_LIMIT) begin
            mStarve++;
         end
         if (eIGnt) iHeld = 0;
         if (eDGnt) dHeld = 0;
         if (mBusy) begin
            if (respond) mBusy = 0;
            else mWaitCnt++;
         end else if (eIGnt || eDGnt) begin
            mBusy    = 1;
            mOwnerI  = eIGnt;
            mWaitCnt = 0;
            mLat     = $urandom_range(1, 5);
         end
      end

`ifdef ARB_TIMEOUT_EN
      // Memory never answers a fetch: watchdog returns a NOP after TIMEOUT silent cycles.
      doReset();
      iReq = 1'b1; iAddr = 32'h400; mGnt = 1'b1;
      #3;
      checkOutput("wd i_gnt", 32'(iGnt), 32'd1);
      for (int k = 0; k <= TIMEOUT; k++) begin
         nextCycle();
         idleInputs();
         #3;
         checkOutput($sformatf("wd%0d i_rvalid", k), 32'(iRvalid), 32'(k == TIMEOUT));
         checkOutput($sformatf("wd%0d err", k), 32'(err), 32'(k == TIMEOUT));
         checkOutput($sformatf("wd%0d busy", k), 32'(busy), 32'd1);
         if (k == TIMEOUT) begin
            checkOutput("wd i_rdata", iRdata, 32'h00000013);
         end
      end
      nextCycle();
      #3;
      checkOutput("wd after busy", 32'(busy), 32'd0);
      checkOutput("wd after err", 32'(err), 32'd0);
      checkOutput("wd after i_rvalid", 32'(iRvalid), 32'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
